// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the FP adder arbiter: FSM states, operand width, pointer step.
package fp_arb_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSendA,
    StSendB,
    StWaitZ,
    StResp
  } state_e;

  // Round-robin successor of idx among n slots.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/fp_adder_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int unsigned    cand;
    logic [IW-1:0]  cand_idx;
    found_o  = 1'b0;
    grant_o  = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr_i) + k) % N;
      cand_idx = IW'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one strobe/ack FP adder among N_REQ requesters, one operation at a time, round-robin.
module fp_adder_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = FP_W,
  parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       resp_z,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [W-1:0]       add_a,
  output logic               add_a_stb,
  input  logic               add_a_ack,
  output logic [W-1:0]       add_b,
  output logic               add_b_stb,
  input  logic               add_b_ack,
  input  logic [W-1:0]       add_z,
  input  logic               add_z_stb,
  output logic               add_z_ack,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [W-1:0]     add_a_q, add_a_d;
  logic [W-1:0]     add_b_q, add_b_d;
  logic [W-1:0]     resp_z_q, resp_z_d;

  logic             pick_found;
  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .grant_o (pick_oh),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    resp_z_d   = resp_z_q;
    req_ready  = '0;
    resp_valid = '0;
    add_a_stb  = 1'b0;
    add_b_stb  = 1'b0;
    add_z_ack  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // req_ready is combinational from the pick, so keep it quiet while reset is held.
        if (pick_found && !rst) begin
          req_ready  = pick_oh;
          add_a_d    = req_a[32'(pick_idx) * W +: W];
          add_b_d    = req_b[32'(pick_idx) * W +: W];
          grant_id_d = pick_idx;
          rr_ptr_d   = IDW'(next_idx(32'(pick_idx), N_REQ));
          state_d    = StSendA;
        end
      end
      StSendA: begin
        add_a_stb = 1'b1;
        if (add_a_ack) state_d = StSendB;
      end
      StSendB: begin
        add_b_stb = 1'b1;
        if (add_b_ack) state_d = StWaitZ;
      end
      StWaitZ: begin
        if (add_z_stb) begin
          add_z_ack = 1'b1;
          resp_z_d  = add_z;
          state_d   = StResp;
        end
      end
      StResp: begin
        resp_valid[grant_id_q] = 1'b1;
        if (resp_ready[grant_id_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      resp_z_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      resp_z_q   <= resp_z_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_id_q;
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign resp_z   = resp_z_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter with a behavioural strobe/ack adder and directed vectors.
module tb_fp_adder_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned IDW = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     resp_z, add_a, add_b, add_z;
  logic             add_a_stb, add_a_ack, add_b_stb, add_b_ack;
  logic             add_z_stb, add_z_ack, busy;
  logic [IDW-1:0]   grant_id;
  logic [N-1:0]     rdy_mask;

  fp_adder_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_z     (resp_z),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .add_a      (add_a),
    .add_a_stb  (add_a_stb),
    .add_a_ack  (add_a_ack),
    .add_b      (add_b),
    .add_b_stb  (add_b_stb),
    .add_b_ack  (add_b_ack),
    .add_z      (add_z),
    .add_z_stb  (add_z_stb),
    .add_z_ack  (add_z_ack),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign resp_ready = rdy_mask;

  // ---------------- adder model ----------------
  int          a_dly = 0, b_dly = 0, z_dly = 3;
  int          a_cnt, b_cnt, z_cnt;
  logic        spur = 1'b0;
  logic        z_pend;
  logic [W-1:0] a_lat, b_lat;

  function automatic logic [W-1:0] fp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;  // 1.0 + 2.0 = 3.0
      64'h40800000_40800000: return 32'h41000000;  // 4.0 + 4.0 = 8.0
      64'h40000000_40800000: return 32'h40C00000;  // 2.0 + 4.0 = 6.0
      64'h3F000000_3F800000: return 32'h3FC00000;  // 0.5 + 1.0 = 1.5
      64'h40000000_40000000: return 32'h40800000;  // 2.0 + 2.0 = 4.0
      64'h3F800000_BF800000: return 32'h00000000;  // 1.0 - 1.0 = 0.0
      default:               return 32'hBADBADBA;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; z_pend <= 1'b0; a_lat <= '0; b_lat <= '0;
    end else begin
      a_cnt <= add_a_stb ? a_cnt + 1 : 0;
      b_cnt <= add_b_stb ? b_cnt + 1 : 0;
      if (add_a_stb && add_a_ack) a_lat <= add_a;
      if (add_b_stb && add_b_ack) begin
        b_lat <= add_b; z_pend <= 1'b1; z_cnt <= 0;
      end else if (z_pend && add_z_stb && add_z_ack) z_pend <= 1'b0;
      else if (z_pend) z_cnt <= z_cnt + 1;
    end
  end

  assign add_a_ack = (add_a_stb && a_cnt >= a_dly) || spur;
  assign add_b_ack = (add_b_stb && b_cnt >= b_dly) || spur;
  assign add_z_stb = (z_pend && z_cnt >= z_dly) || spur;
  assign add_z     = fp_sum(a_lat, b_lat);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   z;
  } exp_t;

  exp_t gnt_q[$], op_q[$], rsp_q[$];
  exp_t mg, mo, mr;
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        if (gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: req_ready=%b, none expected", req_ready);
        end else begin
          mg = gnt_q.pop_front();
          check("grant_onehot", req_ready, onehot(mg.id));
        end
      end
      if (add_a_stb && add_a_ack) begin
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_a_xfer: add_a=%h, none expected", add_a);
        end else check("add_a_value", add_a, op_q[0].a);
      end
      if (add_b_stb && add_b_ack) begin
        if (op_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b_xfer: add_b=%h, none expected", add_b);
        end else begin
          mo = op_q.pop_front();
          check("add_b_value", add_b, mo.b);
        end
      end
      if ((resp_valid & resp_ready) != '0) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: resp_valid=%b resp_z=%h", resp_valid, resp_z);
        end else begin
          mr = rsp_q.pop_front();
          check("resp_onehot", resp_valid, onehot(mr.id));
          check("resp_z", resp_z, mr.z);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic expect_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] z, input bit with_rsp);
    exp_t e;
    e.id = IDW'(i); e.a = a; e.b = b; e.z = z;
    gnt_q.push_back(e);
    op_q.push_back(e);
    if (with_rsp) rsp_q.push_back(e);
  endtask

  // Wait for requester i to be granted, then withdraw its request.
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    check("wait_ready_in_time", 128'(n < 100), 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("wait_idle_in_time", 128'(n < 200), 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({req_ready, resp_valid, resp_z, add_a, add_b, add_a_stb, add_b_stb,
                 add_z_ack, busy, grant_id});
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    int cyc, grants, sa, sb, zk, unstable, n;
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rdy_mask = '1;
    #2 rst = 1'b1;
    #1 check("reset_outputs", all_outs(), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Single request: 1.0 + 2.0 on requester 0.
    set_req(0, 32'h3F800000, 32'h40000000);
    expect_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
    @(negedge clk);
    check("single_req_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    check("single_busy_grant", {busy, grant_id}, {1'b1, 2'd0});
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      if (resp_valid[0]) break;
      cyc++;
    end
    check("single_latency", cyc, 7);
    @(posedge clk); #1;
    check("single_busy_drop", busy, 0);

    // Contention: 0,1,3 held from rr_ptr=0 -> 0,1,3,0.
    rst = 1'b1; #1; @(posedge clk); #1 rst = 1'b0;
    set_req(0, 32'h3F800000, 32'h40000000);
    set_req(1, 32'h40800000, 32'h40800000);
    set_req(3, 32'h40000000, 32'h40800000);
    expect_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
    expect_op(1, 32'h40800000, 32'h40800000, 32'h41000000, 1);
    expect_op(3, 32'h40000000, 32'h40800000, 32'h40C00000, 1);
    expect_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
    grants = 0; n = 0;
    while (grants < 4 && n < 200) begin
      @(negedge clk);
      if (req_ready != '0) grants++;
      n++;
    end
    check("contention_grants", grants, 4);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Slow adder: A ack after 4 extra cycles, B after 2.
    a_dly = 4; b_dly = 2;
    set_req(1, 32'h3F000000, 32'h3F800000);
    expect_op(1, 32'h3F000000, 32'h3F800000, 32'h3FC00000, 1);
    wait_ready(1);
    sa = 0; sb = 0; zk = 0; unstable = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (add_a_stb) begin sa++; if (add_a !== 32'h3F000000) unstable++; end
      if (add_b_stb) begin sb++; if (add_b !== 32'h3F800000) unstable++; end
      if (add_z_ack) zk++;
      if (resp_valid != '0) break;
    end
    check("slow_a_stb_cycles", sa, 5);
    check("slow_b_stb_cycles", sb, 3);
    check("slow_z_ack_pulse", zk, 1);
    check("slow_operands_stable", unstable, 0);
    wait_idle();
    a_dly = 0; b_dly = 0;

    // Backpressure: requester 2 holds off its result while 1 waits.
    rdy_mask[2] = 1'b0;
    set_req(2, 32'h40000000, 32'h40000000);
    expect_op(2, 32'h40000000, 32'h40000000, 32'h40800000, 1);
    wait_ready(2);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (resp_valid[2]) break;
      n++;
    end
    check("bp_resp_seen", 128'(n < 50), 1);
    @(posedge clk); #1;
    set_req(1, 32'h40800000, 32'h40800000);
    expect_op(1, 32'h40800000, 32'h40800000, 32'h41000000, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_hold", {resp_valid, resp_z, req_ready}, {4'b0100, 32'h40800000, 4'b0000});
    end
    @(posedge clk); #1 rdy_mask = '1;
    wait_ready(1);
    wait_idle();

    // Reset mid-operation in WAIT_Z.
    z_dly = 20;
    set_req(1, 32'h3F000000, 32'h3F800000);
    expect_op(1, 32'h3F000000, 32'h3F800000, 32'h3FC00000, 0);
    wait_ready(1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (busy && !add_a_stb && !add_b_stb && resp_valid == '0) break;
      n++;
    end
    check("reached_wait_z", 128'(n < 20), 1);
    #2 rst = 1'b1;
    #1 check("midop_reset_outputs", all_outs(), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    z_dly = 3;
    set_req(2, 32'h3F800000, 32'hBF800000);
    expect_op(2, 32'h3F800000, 32'hBF800000, 32'h00000000, 1);
    wait_ready(2);

    // Wrap and withdrawal: rr_ptr=3, requester 3 pulses while busy, then 0 asks.
    set_req(3, 32'h40000000, 32'h40000000);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    set_req(0, 32'h40000000, 32'h40800000);
    expect_op(0, 32'h40000000, 32'h40800000, 32'h40C00000, 1);
    wait_ready(0);
    wait_idle();

    // Spurious handshakes while idle are ignored.
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
    check("spurious_ignored", {busy, resp_valid}, 0);

    repeat (3) @(posedge clk);
    check("queues_empty", gnt_q.size() + op_q.size() + rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
